// File: rtl/fcvt_pkg.sv
// Shared types and conversion arithmetic for the FP<->int conversion scheduler.
// fcvt_ftoi models fcvt.w.s: round half up in magnitude, then apply sign; no NaN/overflow handling.
// fcvt_itof models fcvt.s.w: round to nearest, ties up in magnitude.
package fcvt_pkg;

    typedef enum logic {FCVT_FTOI = 1'b0, FCVT_ITOF = 1'b1} fcvt_op_e;

    localparam int FCVT_LAT   = 1;
    localparam int FCVT_TAG_W = 5;

    typedef struct packed {
        fcvt_op_e                op;
        logic [FCVT_TAG_W-1:0]   tag;
        logic [31:0]             y;
    } fcvt_res_t;

    function automatic logic [31:0] fcvt_ftoi(input logic [31:0] x);
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] mag;
        logic [4:0]  sh;
        e   = x[30:23];
        m   = {8'd0, 1'b1, x[22:0]};
        mag = '0;
        sh  = '0;
        if (e >= 8'd150) begin
            mag = m << (e - 8'd150);
        end else if (e >= 8'd126) begin
            // shift of 1..24; adding half an LSB before truncation gives round-half-up
            sh  = 5'(8'd150 - e);
            mag = (m + (32'd1 << (sh - 5'd1))) >> sh;
        end
        return x[31] ? (~mag + 32'd1) : mag;
    endfunction

    function automatic logic [31:0] fcvt_itof(input logic [31:0] x);
        logic [31:0] mag;
        logic [4:0]  p;
        logic [4:0]  sh;
        logic [7:0]  ex;
        logic [22:0] frac;
        logic [32:0] rnd;
        logic [31:0] res;
        mag  = x[31] ? (~x + 32'd1) : x;
        p    = '0;
        sh   = '0;
        rnd  = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = 5'(i);
        end
        ex = 8'd127 + {3'd0, p};
        if (p <= 5'd23) begin
            frac = 23'(mag << (5'd23 - p));
        end else begin
            sh  = p - 5'd23;
            rnd = ({1'b0, mag} + (33'd1 << (sh - 5'd1))) >> sh;
            // rounding can carry into a new leading bit: bump exponent, mantissa becomes zero
            if (rnd[24]) begin
                ex   = ex + 8'd1;
                frac = '0;
            end else begin
                frac = rnd[22:0];
            end
        end
        res = (mag == 32'd0) ? 32'd0 : {x[31], ex, frac};
        return res;
    endfunction

endpackage

// File: rtl/fcvt_res_fifo.sv
// Circular result FIFO with wrap-bit pointers; head is read straight from the
// flop array at the registered read pointer, so it is stable until popped.
// Flush empties it on the next edge and overrides a same-cycle push or pop.
module fcvt_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] mem [DEPTH];
    logic         full;

    assign full       = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign head_valid = (wr_ptr_reg != rd_ptr_reg);
    assign head_data  = mem[rd_ptr_reg[AW-1:0]];

    // storage: data needs no reset, validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // pointers: push and pop advance independently, flush returns both to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) (push && !flush) |-> !full);

endmodule

// File: rtl/fcvt_sched.sv
// Issue/return controller for one ftoi and one itof conversion unit.
// Requests are accepted only when a FIFO slot is guaranteed for the result
// (count + inflight < FIFO_DEPTH), because the units cannot stall.
// Optional per-op request counters: define FCVT_SCHED_STATS_EN.
import fcvt_pkg::*;

module fcvt_sched #(
    parameter int TAG_W      = FCVT_TAG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  fcvt_op_e          req_op,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [31:0]       req_x,
    output logic              resp_valid,
    input  logic              resp_ready,
    output fcvt_op_e          resp_op,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [31:0]       resp_y
`ifdef FCVT_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_ftoi,
    output logic [31:0]       stat_itof
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = 1 + TAG_W + 32;

    logic             accept;
    logic             inflight_valid_reg;
    fcvt_op_e         inflight_op_reg;
    logic [TAG_W-1:0] inflight_tag_reg;
    logic [31:0]      ftoi_y_reg;
    logic [31:0]      itof_y_reg;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic [DW-1:0]    push_data;
    logic [DW-1:0]    head_data;

    // credit check uses registered state only, so a pop frees its slot one cycle later
    assign req_ready = !rst && !flush &&
                       (({1'b0, count} + {{CW{1'b0}}, inflight_valid_reg}) < (CW+1)'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // unit stage registers: unreset, only ever observed when inflight_valid_reg is set
    always_ff @(posedge clk) begin
        if (accept) begin
            ftoi_y_reg <= fcvt_ftoi(req_x);
            itof_y_reg <= fcvt_itof(req_x);
        end
    end

    // inflight tracker: accept is already blocked during flush, so flush clears it too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_valid_reg <= 1'b0;
            inflight_op_reg    <= FCVT_FTOI;
            inflight_tag_reg   <= '0;
        end else begin
            inflight_valid_reg <= accept;
            if (accept) begin
                inflight_op_reg  <= req_op;
                inflight_tag_reg <= req_tag;
            end
        end
    end

    assign push      = inflight_valid_reg && !flush;
    assign push_data = {inflight_op_reg, inflight_tag_reg,
                        (inflight_op_reg == FCVT_ITOF) ? itof_y_reg : ftoi_y_reg};
    assign pop       = resp_valid && resp_ready;

    fcvt_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (resp_valid),
        .count      (count)
    );

    assign resp_op  = fcvt_op_e'(head_data[DW-1]);
    assign resp_tag = head_data[DW-2 -: TAG_W];
    assign resp_y   = head_data[31:0];

`ifdef FCVT_SCHED_STATS_EN
    // saturating per-op counters of accepted requests; flush does not clear them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ftoi <= '0;
            stat_itof <= '0;
        end else if (accept) begin
            if (req_op == FCVT_FTOI && stat_ftoi != 32'hFFFF_FFFF) stat_ftoi <= stat_ftoi + 32'd1;
            if (req_op == FCVT_ITOF && stat_itof != 32'hFFFF_FFFF) stat_itof <= stat_itof + 32'd1;
        end
    end
`endif

endmodule
